// File: rtl/tdm_demux_4ch_pkg.sv
// Shared constants and state encoding for the 4-channel TDM demultiplexer.
package tdm_demux_4ch_pkg;
   localparam int NUM_CH = 4;
   localparam int SLOT_W = 2;
   typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/tdm_demux_4ch_if.sv
// Stream-in / frame-out bundle for tdm_demux_4ch; master drives samples, slave is the demux.
interface tdm_demux_4ch_if #(parameter int WIDTH = 1);
   import tdm_demux_4ch_pkg::*;
   logic [WIDTH-1:0]  din;
   logic              din_valid;
   logic              frame_sync;
   logic [WIDTH-1:0]  y0;
   logic [WIDTH-1:0]  y1;
   logic [WIDTH-1:0]  y2;
   logic [WIDTH-1:0]  y3;
   logic              out_valid;
   logic [SLOT_W-1:0] sel;
   logic              locked;
   logic              sync_err;

   modport master (output din, din_valid, frame_sync,
                   input  y0, y1, y2, y3, out_valid, sel, locked, sync_err);
   modport slave  (input  din, din_valid, frame_sync,
                   output y0, y1, y2, y3, out_valid, sel, locked, sync_err);
endinterface

// File: rtl/tdm_demux_4ch_slot.sv
// Slot index counter: clear beats load-1, load-1 beats increment; wraps naturally 3 -> 0.
module tdm_slot_counter
   import tdm_demux_4ch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load1,
   input  logic              inc,
   output logic [SLOT_W-1:0] sel
);
   always_ff @(posedge clk) begin
      if (rst || clr)
         sel <= '0;
      else if (load1)
         sel <= SLOT_W'(1);
      else if (inc)
         sel <= sel + 1'b1;
   end
endmodule

// File: rtl/tdm_demux_4ch.sv
// 4:1 TDM demultiplexer: collects four accepted samples per frame_sync-aligned frame
// and publishes them together on y0..y3 with a one-cycle out_valid.
//
//   state  | meaning
//   HUNT   | waiting for a frame_sync beat; non-sync beats are dropped
//   LOCKED | collecting slots 1..3, checking sync alignment at every slot 0
module tdm_demux_4ch
   import tdm_demux_4ch_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   tdm_demux_4ch_if.slave bus
);
   localparam logic [0:0]        ST_HUNT   = 1'(HUNT);
   localparam logic [0:0]        ST_LOCKED = 1'(LOCKED);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

   logic [0:0]        state;
   logic [SLOT_W-1:0] sel;
   logic [WIDTH-1:0]  stg0, stg1, stg2;
   logic              is_locked;
   logic              cnt_clr, cnt_load1, cnt_inc;

   assign is_locked = (state == ST_LOCKED);
   assign cnt_load1 = bus.din_valid &  bus.frame_sync;
   assign cnt_clr   = bus.din_valid & ~bus.frame_sync & is_locked & (sel == '0);
   assign cnt_inc   = bus.din_valid & ~bus.frame_sync & is_locked & (sel != '0);

   tdm_slot_counter u_slot (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .sel   (sel)
   );

   assign bus.sel    = sel;
   assign bus.locked = is_locked;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_HUNT;
         stg0          <= '0;
         stg1          <= '0;
         stg2          <= '0;
         bus.y0        <= '0;
         bus.y1        <= '0;
         bus.y2        <= '0;
         bus.y3        <= '0;
         bus.out_valid <= 1'b0;
         bus.sync_err  <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         bus.sync_err  <= 1'b0;
         if (bus.din_valid) begin
            if (bus.frame_sync) begin
               // A sync mid-frame restarts the frame; stale staging is overwritten before use.
               stg0  <= bus.din;
               state <= ST_LOCKED;
               if (is_locked && sel != '0)
                  bus.sync_err <= 1'b1;
            end else if (is_locked) begin
               case (sel)
                  2'd0: begin
                     bus.sync_err <= 1'b1;
                     state        <= ST_HUNT;
                  end
                  2'd1: stg1 <= bus.din;
                  2'd2: stg2 <= bus.din;
                  LAST_SLOT: begin
                     bus.y0        <= stg0;
                     bus.y1        <= stg1;
                     bus.y2        <= stg2;
                     bus.y3        <= bus.din;
                     bus.out_valid <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: directed frame scenarios plus randomized traffic vs a queue-based frame model.
module tb_tdm_demux_4ch;
   localparam int W = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tdm_demux_4ch_if #(.WIDTH(W)) bus ();
   tdm_demux_4ch #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: sync state, partial frame as a queue, published frame
   bit             m_locked;
   logic [W-1:0]   m_frame[$];
   logic [W-1:0]   m_y[4];
   bit             m_ov, m_err;

   function automatic logic [W-1:0] act_y(input int s);
      case (s)
         0: return bus.y0;
         1: return bus.y1;
         2: return bus.y2;
         default: return bus.y3;
      endcase
   endfunction

   task automatic beat(input bit r, input bit v, input bit fs, input logic [W-1:0] d);
      rst = r; bus.din_valid = v; bus.frame_sync = fs; bus.din = d;
      @(posedge clk); #1;
      m_ov = 0; m_err = 0;
      if (r) begin
         m_locked = 0; m_frame.delete();
         foreach (m_y[i]) m_y[i] = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (fs) begin m_frame = {d}; m_locked = 1; end
         end else if (fs) begin
            if (m_frame.size() != 0) m_err = 1;
            m_frame = {d};
         end else if (m_frame.size() == 0) begin
            m_err = 1; m_locked = 0;
         end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
               foreach (m_y[i]) m_y[i] = m_frame[i];
               m_ov = 1; m_frame.delete();
            end
         end
      end
   endtask

   task automatic test_reset();
      beat(1, 1, 1, 1'b1);
      beat(1, 0, 0, 1'b0);
      n_checks++;
      if ({bus.y0, bus.y1, bus.y2, bus.y3} !== '0) $display("FAIL reset_y got %b want 0", {bus.y0, bus.y1, bus.y2, bus.y3}); else n_pass++;
      n_checks++;
      if ({bus.out_valid, bus.sync_err, bus.locked} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.out_valid, bus.sync_err, bus.locked}); else n_pass++;
      n_checks++;
      if (bus.sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", bus.sel); else n_pass++;
   endtask

   task automatic test_basic_frame();
      int iv[4] = '{1, 0, 1, 1};
      for (int b = 0; b < 4; b++) begin
         beat(0, 1, b == 0, W'(iv[b]));
         n_checks++;
         if (bus.out_valid !== (b == 3)) $display("FAIL basic_ov beat %0d got %b", b, bus.out_valid); else n_pass++;
      end
      for (int s = 0; s < 4; s++) begin
         n_checks++;
         if (act_y(s) !== W'(iv[s])) $display("FAIL basic_mux slot %0d got %b want %0d", s, act_y(s), iv[s]); else n_pass++;
      end
      beat(0, 1, 1, 1'b0);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL basic_ov_pulse got %b want 0", bus.out_valid); else n_pass++;
      beat(1, 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int dv[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
      int pulses[$];
      for (int b = 0; b < 8; b++) begin
         beat(0, 1, (b % 4) == 0, W'(dv[b]));
         if (bus.out_valid === 1'b1) pulses.push_back(b);
      end
      n_checks++;
      if (pulses.size() != 2) $display("FAIL b2b_pulse_count got %0d want 2", pulses.size());
      else if (pulses[1] - pulses[0] != 4 || pulses[0] != 3) $display("FAIL b2b_spacing got %0d,%0d want 3,7", pulses[0], pulses[1]);
      else n_pass++;
      n_checks++;
      if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 4'b0110) $display("FAIL b2b_frame2 got %b want 0110", {bus.y0, bus.y1, bus.y2, bus.y3}); else n_pass++;
   endtask

   task automatic test_gaps();
      int dv[4] = '{1, 0, 1, 1};
      for (int b = 0; b < 4; b++) begin
         beat(0, 1, b == 0, W'(dv[b]));
         for (int g = 0; g < 2; g++) begin
            beat(0, 0, 1, 1'b0);
            n_checks++;
            if (bus.sel !== 2'((b + 1) % 4) || bus.out_valid !== 1'b0 || bus.sync_err !== 1'b0)
               $display("FAIL gap_hold beat %0d got sel=%0d ov=%b err=%b want sel=%0d ov=0 err=0", b, bus.sel, bus.out_valid, bus.sync_err, (b + 1) % 4);
            else n_pass++;
         end
         if (b == 3) begin
            n_checks++;
            if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 4'b1011) $display("FAIL gap_frame got %b want 1011", {bus.y0, bus.y1, bus.y2, bus.y3}); else n_pass++;
         end
      end
   endtask

   task automatic test_early_sync();
      bit saw_ov = 0;
      beat(0, 1, 1, 1'b0);
      beat(0, 1, 0, 1'b0);
      beat(0, 1, 1, 1'b1);
      n_checks++;
      if ({bus.sync_err, bus.out_valid, bus.locked} !== 3'b101 || bus.sel !== 2'd1)
         $display("FAIL early_sync got err=%b ov=%b lk=%b sel=%0d want 1 0 1 1", bus.sync_err, bus.out_valid, bus.locked, bus.sel);
      else n_pass++;
      beat(0, 1, 0, 1'b0); if (bus.out_valid) saw_ov = 1;
      beat(0, 1, 0, 1'b0); if (bus.out_valid) saw_ov = 1;
      n_checks++;
      if (saw_ov) $display("FAIL early_no_ov got pulse want none"); else n_pass++;
      beat(0, 1, 0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 4'b1001)
         $display("FAIL early_refill got ov=%b y=%b want 1 1001", bus.out_valid, {bus.y0, bus.y1, bus.y2, bus.y3});
      else n_pass++;
   endtask

   task automatic test_missing_sync();
      beat(0, 1, 0, 1'b1);
      n_checks++;
      if ({bus.sync_err, bus.locked} !== 2'b10 || bus.sel !== 2'd0)
         $display("FAIL miss_sync got err=%b lk=%b sel=%0d want 1 0 0", bus.sync_err, bus.locked, bus.sel);
      else n_pass++;
      for (int b = 0; b < 5; b++) begin
         beat(0, 1, 0, W'(b));
         n_checks++;
         if ({bus.sync_err, bus.locked, bus.out_valid} !== 3'b000 || bus.sel !== 2'd0)
            $display("FAIL hunt_ignore beat %0d got err=%b lk=%b ov=%b sel=%0d", b, bus.sync_err, bus.locked, bus.out_valid, bus.sel);
         else n_pass++;
      end
      beat(0, 1, 1, 1'b1);
      n_checks++;
      if (bus.locked !== 1'b1 || bus.sel !== 2'd1) $display("FAIL relock got lk=%b sel=%0d want 1 1", bus.locked, bus.sel); else n_pass++;
   endtask

   task automatic test_mid_reset();
      beat(0, 1, 1, 1'b1);
      beat(0, 1, 0, 1'b1);
      n_checks++;
      if (bus.sel !== 2'd2) $display("FAIL pre_reset_sel got %0d want 2", bus.sel); else n_pass++;
      beat(1, 1, 0, 1'b1);
      n_checks++;
      if ({bus.y0, bus.y1, bus.y2, bus.y3, bus.out_valid, bus.locked, bus.sync_err} !== '0 || bus.sel !== 2'd0)
         $display("FAIL mid_reset got y=%b ov=%b lk=%b sel=%0d want all 0", {bus.y0, bus.y1, bus.y2, bus.y3}, bus.out_valid, bus.locked, bus.sel);
      else n_pass++;
      beat(0, 1, 0, 1'b1);
      beat(0, 1, 0, 1'b1);
      n_checks++;
      if ({bus.out_valid, bus.locked, bus.sync_err} !== 3'b000) $display("FAIL post_reset_hunt got ov=%b lk=%b err=%b", bus.out_valid, bus.locked, bus.sync_err); else n_pass++;
   endtask

   task automatic test_random();
      bit r, v, fs;
      for (int c = 0; c < 3000; c++) begin
         r  = ($urandom_range(0, 299) == 0);
         v  = ($urandom_range(0, 3) != 0);
         fs = (m_frame.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
         beat(r, v, fs, W'($urandom));
         n_checks++;
         if (bus.out_valid !== m_ov) $display("FAIL rnd_ov cyc %0d got %b want %b", c, bus.out_valid, m_ov); else n_pass++;
         n_checks++;
         if (bus.sync_err !== m_err) $display("FAIL rnd_err cyc %0d got %b want %b", c, bus.sync_err, m_err); else n_pass++;
         n_checks++;
         if (bus.locked !== m_locked) $display("FAIL rnd_locked cyc %0d got %b want %b", c, bus.locked, m_locked); else n_pass++;
         n_checks++;
         if (bus.sel !== 2'(m_frame.size())) $display("FAIL rnd_sel cyc %0d got %0d want %0d", c, bus.sel, m_frame.size()); else n_pass++;
         n_checks++;
         if ({bus.y0, bus.y1, bus.y2, bus.y3} !== {m_y[0], m_y[1], m_y[2], m_y[3]})
            $display("FAIL rnd_y cyc %0d got %b want %b", c, {bus.y0, bus.y1, bus.y2, bus.y3}, {m_y[0], m_y[1], m_y[2], m_y[3]});
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; bus.din_valid = 1'b0; bus.frame_sync = 1'b0; bus.din = '0;
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_gaps();
      test_early_sync();
      test_missing_sync();
      test_mid_reset();
      beat(1, 0, 0, 1'b0);
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter WIDTH, default 1, sets the bit width of each sample and each channel output.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 din  input  WIDTH  serial TDM sample stream, one channel sample per accepted beat.
REQ-005 din_valid  input  1  when high, the current din is accepted on this clock edge.
REQ-006 frame_sync  input  1  qualified by din_valid; marks the accepted sample as slot 0.
REQ-007 y0, y1, y2, y3  output  WIDTH each  registered channel outputs for slots 0 to 3.
REQ-008 out_valid  output  1  one-cycle pulse; y0 to y3 hold one coherent new frame.
REQ-009 sel  output  2  slot index expected for the next accepted sample.
REQ-010 locked  output  1  high while the state is LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 The block SHALL implement a two-state FSM with states HUNT and LOCKED.
REQ-013 With din_valid=0, the block SHALL hold all state and outputs; out_valid and sync_err SHALL be 0, and frame_sync SHALL be ignored.
REQ-014 HUNT: an accepted sample with frame_sync=0 SHALL be discarded, with no output change.
REQ-015 HUNT: an accepted sample with frame_sync=1 SHALL be stored as staging slot 0, set sel to 1, and move the FSM to LOCKED.
REQ-016 LOCKED, sel=1 or 2, frame_sync=0: the sample SHALL be stored in staging[sel], and sel SHALL increment.
REQ-017 LOCKED, sel=3, frame_sync=0: on that edge, y0 to y2 SHALL load staging[0..2], y3 SHALL load din, sel SHALL wrap to 0, and out_valid SHALL be 1 for the following cycle only.
REQ-018 Frame latency: out_valid SHALL rise in the cycle after the slot-3 sample is accepted.
REQ-019 y0 to y3 SHALL change only together with an out_valid pulse; partial frames SHALL never reach the outputs.
REQ-020 LOCKED, sel=0, frame_sync=1: the sample SHALL be stored as slot 0, and sel SHALL become 1 (normal frame start).
REQ-021 LOCKED, sel≠0, frame_sync=1 (early sync): sync_err SHALL pulse, the partial frame SHALL be discarded, the sample SHALL be stored as slot 0, sel SHALL become 1, and the FSM SHALL stay LOCKED.
REQ-022 LOCKED, sel=0, frame_sync=0 (missing sync): sync_err SHALL pulse, the sample SHALL be discarded, the FSM SHALL enter HUNT, and sel SHALL become 0.
REQ-023 Back-to-back frames with din_valid held high SHALL sustain one out_valid pulse every 4 cycles, with no bubble.
REQ-024 sel SHALL be a 2-bit counter with natural wrap from 3 to 0; no other slot value exists.

Reset
REQ-025 With rst=1 at a rising edge, the block SHALL set state HUNT, sel=0, y0 to y3 = 0, staging = 0, out_valid=0, sync_err=0, and locked=0.
REQ-026 rst SHALL take priority over din_valid and frame_sync, and a mid-frame reset SHALL discard the partial frame without an out_valid pulse.
REQ-027 The first sample after rst deasserts SHALL be handled per HUNT rules.

Structure
REQ-028 A shared package SHALL hold NUM_CH=4, SLOT_W=2, and the state enum {HUNT, LOCKED}.
REQ-029 One sub-module, tdm_slot_counter, SHALL own sel, with inputs for clear, load-1, and increment.

Verification
REQ-030 WIDTH=1, a reset pulse, then din=1,0,1,1 with frame_sync on the first beat -> out_valid one cycle after the 4th beat, with y0..y3=1,0,1,1, matching a 4:1 mux with I0..I3 = 1,0,1,1.
REQ-031 Two back-to-back frames, 1,0,1,1 then 0,1,1,0, with din_valid continuous -> out_valid pulses 4 cycles apart, and the second frame gives y0..y3=0,1,1,0.
REQ-032 Frame with din_valid=0 gaps between beats -> sel holds during the gaps, and out_valid fires only after the 4th accepted beat, with the same data.
REQ-033 frame_sync asserted on beat 3 of a frame -> sync_err pulse, no out_valid for that frame, sel=1, and the next 3 beats complete a new frame.
REQ-034 Beat with frame_sync=0 at sel=0 while LOCKED -> sync_err pulse, locked=0, and non-sync beats are ignored until the next frame_sync.
REQ-035 rst asserted at sel=2 -> all outputs 0 and locked=0, with no out_valid pulse.
